// File: rtl/mem_dp_rd_streamer_if.sv
// Request, RAM-port and output-stream signals of the dual-port RAM read streamer.
// The slave modport is the streamer; the master modport is its environment.
interface mem_dp_rd_streamer_if #(
   parameter int ADR_W  = 9,
   parameter int DATA_W = 16
);
   logic              i_req_valid;
   logic              o_req_ready;
   logic [ADR_W-1:0]  i_req_adr;
   logic [ADR_W-1:0]  i_req_cnt;
   logic              o_mem_en;
   logic [ADR_W-1:0]  o_mem_adr;
   logic [DATA_W-1:0] i_mem_rdata;
   logic              o_data_valid;
   logic [DATA_W-1:0] o_data;
   logic              o_data_last;
   logic              i_data_stall;
   logic              o_done;

   modport slave (
      input  i_req_valid, i_req_adr, i_req_cnt, i_mem_rdata, i_data_stall,
      output o_req_ready, o_mem_en, o_mem_adr, o_data_valid, o_data, o_data_last, o_done
   );

   modport master (
      output i_req_valid, i_req_adr, i_req_cnt, i_mem_rdata, i_data_stall,
      input  o_req_ready, o_mem_en, o_mem_adr, o_data_valid, o_data, o_data_last, o_done
   );
endinterface

// File: rtl/mem_dp_rd_streamer.sv
// Streams a (start address, count) burst out of one RAM read port, hiding the
// one-cycle read latency behind a small credit-limited output buffer.
//
//   state    | meaning
//   ST_IDLE  | ready for a request, nothing pending
//   ST_READ  | issuing reads while buffer credit allows
//   ST_DRAIN | all reads issued, waiting for buffer to empty, then pulse done
module mem_dp_rd_streamer #(
   parameter int ADR_W     = 9,
   parameter int DATA_W    = 16,
   parameter int BUF_DEPTH = 2
) (
   input logic                 clk,
   input logic                 rst,
   mem_dp_rd_streamer_if.slave bus
);
   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int OCC_W = $clog2(BUF_DEPTH + 1);
   localparam logic [OCC_W:0]   DEPTH_C  = (OCC_W+1)'(BUF_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
   localparam logic [ADR_W:0]   REM_ONE  = (ADR_W+1)'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_e;

   state_e            state_q, state_d;
   logic [ADR_W-1:0]  adr_q, adr_d;
   logic [ADR_W:0]    rem_q, rem_d;
   logic              inflight_q, inflight_last_q;
   logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] buf_last_q;
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [OCC_W-1:0]  occ_q;
   logic [OCC_W:0]    credit;
   logic              data_valid, pop, issue;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign data_valid       = (occ_q != '0);
   assign pop              = data_valid & ~bus.i_data_stall;
   // Words held or in flight after this cycle's pop; an issue must keep this below depth.
   assign credit           = (OCC_W+1)'(occ_q) + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
   assign bus.o_mem_en     = issue;
   assign bus.o_mem_adr    = adr_q;
   assign bus.o_data_valid = data_valid;
   assign bus.o_data       = data_valid ? buf_data_q[head_q] : '0;
   assign bus.o_data_last  = data_valid & buf_last_q[head_q];

   always_comb begin
      state_d         = state_q;
      adr_d           = adr_q;
      rem_d           = rem_q;
      issue           = 1'b0;
      bus.o_req_ready = 1'b0;
      bus.o_done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.o_req_ready = 1'b1;
            if (bus.i_req_valid) begin
               adr_d   = bus.i_req_adr;
               // A count of zero means the full address space.
               rem_d   = (bus.i_req_cnt == '0) ? {1'b1, {ADR_W{1'b0}}} : {1'b0, bus.i_req_cnt};
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (credit < DEPTH_C) begin
               issue = 1'b1;
               adr_d = adr_q + 1'b1;
               rem_d = rem_q - 1'b1;
               if (rem_q == REM_ONE) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (occ_q == '0 && !inflight_q) begin
               bus.o_done = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         adr_q           <= '0;
         rem_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         head_q          <= '0;
         tail_q          <= '0;
         occ_q           <= '0;
         buf_last_q      <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) buf_data_q[i] <= '0;
      end else begin
         state_q         <= state_d;
         adr_q           <= adr_d;
         rem_q           <= rem_d;
         inflight_q      <= issue;
         inflight_last_q <= issue && (rem_q == REM_ONE);
         if (inflight_q) begin
            buf_data_q[tail_q] <= bus.i_mem_rdata;
            buf_last_q[tail_q] <= inflight_last_q;
            tail_q             <= ptr_inc(tail_q);
         end
         if (pop) head_q <= ptr_inc(head_q);
         occ_q <= occ_q + OCC_W'(inflight_q) - OCC_W'(pop);
      end
   end
endmodule

// File: tb/tb_mem_dp_rd_streamer.sv
// Randomized scoreboard bench for mem_dp_rd_streamer with a registered-read RAM model.
module tb_mem_dp_rd_streamer;
   localparam int ADR_W  = 9;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 2;
   localparam int NWORDS = 512;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   stall_mode = 0;
   logic [DATA_W-1:0] mem [NWORDS];

   mem_dp_rd_streamer_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

   mem_dp_rd_streamer #(.ADR_W(ADR_W), .DATA_W(DATA_W), .BUF_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (bus.o_mem_en) bus.i_mem_rdata <= mem[bus.o_mem_adr];

   // Scoreboard state, owned by the monitor.
   logic [ADR_W-1:0]  exp_adr [$];
   logic [DATA_W-1:0] exp_data [$];
   bit                exp_last [$];
   int issued, popped, pending, accept_cyc, cur_n, last_pop_cyc, last_done_cyc;
   bit first_pending, stall_seen, waiting_prev, saw_rst, prev_hold, prev_last;
   logic [DATA_W-1:0] prev_data;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      logic [ADR_W-1:0]  a;
      logic [DATA_W-1:0] d;
      bit                l, p;
      int                n;
      if (rst) begin
         exp_adr.delete(); exp_data.delete(); exp_last.delete();
         issued = 0; popped = 0; pending = 0;
         first_pending = 0; waiting_prev = 0; prev_hold = 0; stall_seen = 0;
         saw_rst = 1;
      end else begin
         if (saw_rst) begin
            chk(bus.o_req_ready === 1'b1, "rst_ready", bus.o_req_ready, 1);
            chk(bus.o_data_valid === 1'b0, "rst_valid", bus.o_data_valid, 0);
            chk(bus.o_done === 1'b0, "rst_done", bus.o_done, 0);
            chk(bus.o_mem_en === 1'b0, "rst_mem_en", bus.o_mem_en, 0);
            chk(bus.o_mem_adr === '0, "rst_mem_adr", bus.o_mem_adr, 0);
            chk(bus.o_data === '0 && bus.o_data_last === 1'b0, "rst_data", bus.o_data, 0);
            saw_rst = 0;
         end
         if (prev_hold)
            chk(bus.o_data_valid === 1'b1 && bus.o_data === prev_data && bus.o_data_last === prev_last,
                "stall_hold", bus.o_data, prev_data);
         if (bus.o_mem_en) begin
            issued++;
            chk(exp_adr.size() > 0, "read_expected", exp_adr.size(), 1);
            if (exp_adr.size() > 0) begin
               a = exp_adr.pop_front();
               chk(bus.o_mem_adr === a, "read_adr", bus.o_mem_adr, a);
            end
         end
         p = bus.o_data_valid && !bus.i_data_stall;
         if (bus.o_data_valid && first_pending) begin
            chk(cyc - accept_cyc == 3, "first_latency", cyc - accept_cyc, 3);
            first_pending = 0;
         end
         if (p) begin
            popped++;
            last_pop_cyc = cyc;
            chk(exp_data.size() > 0, "word_expected", exp_data.size(), 1);
            if (exp_data.size() > 0) begin
               d = exp_data.pop_front();
               l = exp_last.pop_front();
               chk(bus.o_data === d, "word_data", bus.o_data, d);
               chk(bus.o_data_last === l, "word_last", bus.o_data_last, l);
            end
         end
         if (bus.o_mem_en) chk(issued - popped <= DEPTH, "credit", issued - popped, DEPTH);
         if (bus.o_data_valid && bus.i_data_stall) stall_seen = 1;
         if (bus.o_done) begin
            chk(pending > 0, "done_expected", pending, 1);
            chk(exp_data.size() == 0 && exp_adr.size() == 0, "done_early", exp_data.size() + exp_adr.size(), 0);
            chk(cyc == last_pop_cyc + 1, "done_timing", cyc - last_pop_cyc, 1);
            if (!stall_seen) chk(cyc - accept_cyc == cur_n + 3, "throughput", cyc - accept_cyc, cur_n + 3);
            if (pending > 0) pending--;
            last_done_cyc = cyc;
         end
         if (bus.i_req_valid && bus.o_req_ready === 1'b1) begin
            if (waiting_prev) chk(cyc == last_done_cyc + 1, "held_req_accept", cyc - last_done_cyc, 1);
            n = (bus.i_req_cnt == '0) ? NWORDS : int'(bus.i_req_cnt);
            for (int k = 0; k < n; k++) begin
               a = ADR_W'((int'(bus.i_req_adr) + k) % NWORDS);
               exp_adr.push_back(a);
               exp_data.push_back(mem[a]);
               exp_last.push_back(k == n - 1);
            end
            accept_cyc = cyc; cur_n = n; first_pending = 1; stall_seen = 0; pending++;
         end
         waiting_prev = bus.i_req_valid && !bus.o_req_ready;
         prev_hold    = bus.o_data_valid && bus.i_data_stall;
         prev_data    = bus.o_data;
         prev_last    = bus.o_data_last;
      end
   end

   // Stall generator: 0 = never, 1 = 3 on / 3 off, 2 = random.
   initial begin
      int k;
      k = 0;
      bus.i_data_stall = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (stall_mode)
            1:       bus.i_data_stall = ((k % 6) < 3);
            2:       bus.i_data_stall = 1'($urandom_range(0, 1));
            default: bus.i_data_stall = 1'b0;
         endcase
         k++;
      end
   end

   task automatic wait_ready(input string what);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.o_req_ready === 1'b1) return;
      end
      $display("FAIL %s: timeout waiting for o_req_ready", what);
      $fatal(1, "timeout");
   endtask

   task automatic wait_done(input string what);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (bus.o_done === 1'b1) begin
            repeat (2) @(posedge clk);
            return;
         end
      end
      $display("FAIL %s: timeout waiting for o_done", what);
      $fatal(1, "timeout");
   endtask

   task automatic req(input int adr, input int cnt);
      @(posedge clk); #1;
      bus.i_req_valid = 1'b1;
      bus.i_req_adr   = ADR_W'(adr);
      bus.i_req_cnt   = ADR_W'(cnt);
      wait_ready("req_accept");
      @(posedge clk); #1;
      bus.i_req_valid = 1'b0;
   endtask

   initial begin
      int pops;
      bus.i_req_valid = 1'b0;
      bus.i_req_adr   = '0;
      bus.i_req_cnt   = '0;
      for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'($urandom);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      stall_mode = 0; req('h010, 4); wait_done("basic");
      req('h1FE, 4); wait_done("wrap");
      stall_mode = 1; req('h123, 8); wait_done("stall_toggle");
      stall_mode = 0; req('h0A5, 0); wait_done("full_512");
      stall_mode = 2;
      for (int t = 0; t < 10; t++) begin
         req(int'($urandom_range(0, NWORDS - 1)), int'($urandom_range(1, 16)));
         wait_done("random");
      end

      // Reset in the middle of a 6-word request.
      stall_mode = 0;
      req('h050, 6);
      pops = 0;
      for (int i = 0; i < 100 && pops < 2; i++) begin
         @(negedge clk);
         if (bus.o_data_valid && !bus.i_data_stall) pops++;
      end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      req('h077, 1); wait_done("after_reset");

      // Request held valid across a whole transfer.
      @(posedge clk); #1;
      bus.i_req_valid = 1'b1;
      bus.i_req_adr   = ADR_W'('h040);
      bus.i_req_cnt   = ADR_W'(3);
      wait_ready("held_first");
      @(posedge clk); #1;
      bus.i_req_adr   = ADR_W'('h1FF);
      wait_ready("held_second");
      @(posedge clk); #1;
      bus.i_req_valid = 1'b0;
      wait_done("held_second_done");
      repeat (4) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
